// File: rtl/iq_trip_pkg.sv
// Shared width helpers and arithmetic for the IQ trip monitor.
// Imported by the sum-of-squares pipeline and the monitor top.
package iq_trip_pkg;

  function automatic int mw_f(input int iw);
    return iw - 1;
  endfunction

  function automatic int sw_f(input int iw);
    return 2 * (iw - 1) + 1;
  endfunction

  function automatic int cw_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int sat_inc(
    input int v,
    input int maxv
  );
    return (v >= maxv) ? maxv : v + 1;
  endfunction

endpackage

// File: rtl/iq_sumsq.sv
// I/Q pairing, ones-complement fold, square and sum pipeline.
// Q accepted at edge k gives sum/sum_valid after edge k+2.
module iq_sumsq
  import iq_trip_pkg::*;
#(
  parameter  int IW  = 9,
  parameter  int NCH = 4,
  localparam int MW  = mw_f(IW),
  localparam int SW  = sw_f(IW),
  localparam int CW  = cw_f(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] in_val,
  input  logic          in_valid,
  input  logic          in_gate,
  input  logic [CW-1:0] in_chan,
  output logic [SW-1:0] sum,
  output logic          sum_valid,
  output logic [CW-1:0] sum_chan
);

  function automatic logic [MW-1:0] fold(
    input logic [IW-1:0] v
  );
    return v[IW-1] ? ~v[MW-1:0] : v[MW-1:0];
  endfunction

  logic            pend_q;
  logic            pend_d;
  logic            fire;
  logic [MW-1:0]   ai_q;
  logic [CW-1:0]   chp_q;

  logic            v1_q;
  logic [MW-1:0]   a1_q;
  logic [MW-1:0]   b1_q;
  logic [CW-1:0]   c1_q;

  logic            v2_q;
  logic [2*MW-1:0] sqi_q;
  logic [2*MW-1:0] sqq_q;
  logic [CW-1:0]   c2_q;

  logic            v3_q;
  logic [SW-1:0]   sum_q;
  logic [CW-1:0]   c3_q;

  // a gated sample always (re)starts a pair, dropping any pending I
  assign pend_d = in_valid & in_gate;
  assign fire   = pend_q & in_valid & ~in_gate;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      v1_q   <= fire;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_d) begin
      ai_q  <= fold(in_val);
      chp_q <= in_chan;
    end
    if (fire) begin
      a1_q <= ai_q;
      b1_q <= fold(in_val);
      c1_q <= chp_q;
    end
    sqi_q <= {{MW{1'b0}}, a1_q} * {{MW{1'b0}}, a1_q};
    sqq_q <= {{MW{1'b0}}, b1_q} * {{MW{1'b0}}, b1_q};
    c2_q  <= c1_q;
    sum_q <= {1'b0, sqi_q} + {1'b0, sqq_q};
    c3_q  <= c2_q;
  end

  assign sum       = sum_q;
  assign sum_valid = v3_q;
  assign sum_chan  = c3_q;

endmodule

// File: rtl/iq_trip_mon.sv
// Multi-channel IQ trip monitor: per-channel persistence count,
// sticky trip flag and peak-hold with registered readout.
module iq_trip_mon
  import iq_trip_pkg::*;
#(
  parameter  int IW  = 9,
  parameter  int NCH = 4,
  parameter  int PW  = 4,
  localparam int SW  = sw_f(IW),
  localparam int CW  = cw_f(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  in_val,
  input  logic           in_valid,
  input  logic           in_gate,
  input  logic [CW-1:0]  in_chan,
  input  logic [SW-1:0]  trip_thresh,
  input  logic [PW-1:0]  persist,
  input  logic [NCH-1:0] trip_clear,
  input  logic [NCH-1:0] peak_clear,
  input  logic [CW-1:0]  rd_chan,
  output logic [NCH-1:0] tripped,
  output logic           trip_any,
  output logic [SW-1:0]  rd_peak
);

  localparam int CNT_MAX = (1 << PW) - 1;

  logic [SW-1:0]  sum;
  logic           sum_valid;
  logic [CW-1:0]  sum_chan;

  logic [PW-1:0]  cnt_q  [NCH];
  logic [PW-1:0]  cnt_d  [NCH];
  logic [SW-1:0]  peak_q [NCH];
  logic [SW-1:0]  peak_d [NCH];
  logic [NCH-1:0] trip_q;
  logic [NCH-1:0] trip_d;
  logic           any_q;
  logic [SW-1:0]  rd_q;
  logic [SW-1:0]  rd_d;
  logic           over;
  int             need;

  iq_sumsq #(
    .IW  (IW),
    .NCH (NCH)
  ) u_sumsq (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_valid  (in_valid),
    .in_gate   (in_gate),
    .in_chan   (in_chan),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_chan  (sum_chan)
  );

  assign over = sum > trip_thresh;

  always_comb begin
    need = (persist == '0) ? 1 : int'(persist);
  end

  // pairs for channels >= NCH match no c and are dropped here
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c]  = cnt_q[c];
      trip_d[c] = trip_q[c];
      peak_d[c] = peak_q[c];
      if (sum_valid && (int'(sum_chan) == c)) begin
        if (over) begin
          cnt_d[c] = PW'(sat_inc(int'(cnt_q[c]), CNT_MAX));
          if (int'(cnt_q[c]) + 1 >= need) begin
            trip_d[c] = 1'b1;
          end
        end else begin
          cnt_d[c] = '0;
        end
        if (sum > peak_q[c]) begin
          peak_d[c] = sum;
        end
      end
      if (trip_clear[c]) begin
        cnt_d[c]  = '0;
        trip_d[c] = 1'b0;
      end
      if (peak_clear[c]) begin
        peak_d[c] = '0;
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(rd_chan) == c) begin
        rd_d = peak_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= '0;
        peak_q[c] <= '0;
      end
      trip_q <= '0;
      any_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      trip_q <= trip_d;
      any_q  <= |trip_q;
      rd_q   <= rd_d;
    end
  end

  assign tripped  = trip_q;
  assign trip_any = any_q;
  assign rd_peak  = rd_q;

endmodule

// File: tb/tb_iq_trip_mon.sv
// Bench for iq_trip_mon: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_iq_trip_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1;
  logic signed [8:0]  in_val = '0;
  logic               in_valid = 1'b0;
  logic               in_gate = 1'b0;
  logic [1:0]         in_chan = '0;
  logic [16:0]        trip_thresh = '0;
  logic [3:0]         persist = 4'd1;
  logic [3:0]         trip_clear = '0;
  logic [3:0]         peak_clear = '0;
  logic [1:0]         rd_chan = '0;
  logic [3:0]         tripped;
  logic               trip_any;
  logic [16:0]        rd_peak;

  logic [2:0]         trip_clear_b;
  logic [2:0]         peak_clear_b;
  logic [2:0]         tripped_b;
  logic               trip_any_b;
  logic [16:0]        rd_peak_b;

  assign trip_clear_b = trip_clear[2:0];
  assign peak_clear_b = peak_clear[2:0];

  iq_trip_mon #(.IW(9), .NCH(4), .PW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_valid    (in_valid),
    .in_gate     (in_gate),
    .in_chan     (in_chan),
    .trip_thresh (trip_thresh),
    .persist     (persist),
    .trip_clear  (trip_clear),
    .peak_clear  (peak_clear),
    .rd_chan     (rd_chan),
    .tripped     (tripped),
    .trip_any    (trip_any),
    .rd_peak     (rd_peak)
  );

  iq_trip_mon #(.IW(9), .NCH(3), .PW(4)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_valid    (in_valid),
    .in_gate     (in_gate),
    .in_chan     (in_chan),
    .trip_thresh (trip_thresh),
    .persist     (persist),
    .trip_clear  (trip_clear_b),
    .peak_clear  (peak_clear_b),
    .rd_chan     (rd_chan),
    .tripped     (tripped_b),
    .trip_any    (trip_any_b),
    .rd_peak     (rd_peak_b)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int due;
    int ch;
    int sum;
  } upd_t;

  upd_t mq[$];
  int   m_cnt[4];
  bit   m_trip[4];
  int   m_peak[4];
  int   cyc = 0;
  bit   m_pend = 1'b0;
  int   m_pi = 0;
  int   m_pch = 0;
  bit   exp_any = 1'b0;
  int   exp_rdpk = 0;

  function automatic int fold(input int v);
    return (v < 0) ? -v - 1 : v;
  endfunction

  function automatic logic [3:0] m_tripped();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = m_trip[c];
    return r;
  endfunction

  function automatic void model_edge();
    upd_t e;
    int   need;
    int   a;
    int   b;
    cyc++;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        m_cnt[c] = 0;
        m_trip[c] = 1'b0;
        m_peak[c] = 0;
      end
      mq.delete();
      m_pend = 1'b0;
      exp_any = 1'b0;
      exp_rdpk = 0;
      return;
    end
    exp_any = |m_tripped();
    exp_rdpk = m_peak[rd_chan];
    while (mq.size() > 0 && mq[0].due == cyc) begin
      e = mq.pop_front();
      need = (persist == 0) ? 1 : int'(persist);
      if (e.sum > int'(trip_thresh)) begin
        if (m_cnt[e.ch] + 1 >= need) m_trip[e.ch] = 1'b1;
        m_cnt[e.ch] = (m_cnt[e.ch] >= 15) ? 15 : m_cnt[e.ch] + 1;
      end else begin
        m_cnt[e.ch] = 0;
      end
      if (e.sum > m_peak[e.ch]) m_peak[e.ch] = e.sum;
    end
    for (int c = 0; c < 4; c++) begin
      if (trip_clear[c]) begin
        m_cnt[c] = 0;
        m_trip[c] = 1'b0;
      end
      if (peak_clear[c]) m_peak[c] = 0;
    end
    if (m_pend && in_valid && !in_gate) begin
      a = fold(m_pi);
      b = fold(int'(in_val));
      mq.push_back(upd_t'{due: cyc + 3, ch: m_pch, sum: a * a + b * b});
    end
    m_pend = in_valid && in_gate;
    if (m_pend) begin
      m_pi = int'(in_val);
      m_pch = int'(in_chan);
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_tripped", int'(tripped), int'(m_tripped()));
    chk("model_trip_any", int'(trip_any), int'(exp_any));
    chk("model_rd_peak", int'(rd_peak), exp_rdpk);
  endtask

  task automatic drive(input bit v, input bit g, input int ch, input int val);
    in_valid = v;
    in_gate = g;
    in_chan = 2'(ch);
    in_val = 9'(val);
  endtask

  task automatic pair(input int ch, input int i, input int q);
    drive(1'b1, 1'b1, ch, i);
    tick();
    drive(1'b1, 1'b0, ch, q);
    tick();
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    trip_clear = '0;
    peak_clear = '0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int ch;
    int i;
    int q;
    int thr;
    int per;
    int exp_trip;
    int exp_pk;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1,  100,  -50, 12400, 1, 4'b0010, 12401};
    tbl[1]  = '{2,  100,  -50, 12400, 3, 4'b0010, 12401};
    tbl[2]  = '{2,  100,  -50, 12400, 3, 4'b0010, 12401};
    tbl[3]  = '{2,   10,   10, 12400, 3, 4'b0010, 12401};
    tbl[4]  = '{2,  100,  -50, 12400, 3, 4'b0010, 12401};
    tbl[5]  = '{2,  100,  -50, 12400, 3, 4'b0010, 12401};
    tbl[6]  = '{2, -101,   49, 12400, 3, 4'b0110, 12401};
    tbl[7]  = '{0, -256, -256, 12400, 0, 4'b0111, 130050};
    tbl[8]  = '{0,   -1,    0, 12400, 1, 4'b0111, 130050};
    tbl[9]  = '{3,  127,  127, 40000, 1, 4'b0111, 32258};
    tbl[10] = '{3,  255,    0, 40000, 1, 4'b1111, 65025};
    tbl[11] = '{3,  200,    0, 40000, 1, 4'b1111, 65025};

    do_reset();
    chk("rst_tripped", int'(tripped), 0);
    chk("rst_trip_any", int'(trip_any), 0);
    chk("rst_rd_peak", int'(rd_peak), 0);

    // single pair timing
    trip_thresh = 17'd12400;
    persist = 4'd1;
    rd_chan = 2'd1;
    pair(1, 100, -50);
    idle(2);
    chk("sp_k2_tripped", int'(tripped), 0);
    tick();
    chk("sp_k3_tripped", int'(tripped), 4'b0010);
    chk("sp_k3_any", int'(trip_any), 0);
    tick();
    chk("sp_k4_any", int'(trip_any), 1);
    chk("sp_k4_peak", int'(rd_peak), 12401);

    // table of cumulative pairs including persistence
    do_reset();
    for (int n = 0; n < 12; n++) begin
      trip_thresh = 17'(tbl[n].thr);
      persist = 4'(tbl[n].per);
      rd_chan = 2'(tbl[n].ch);
      pair(tbl[n].ch, tbl[n].i, tbl[n].q);
      idle(4);
      chk($sformatf("tbl%0d_tripped", n), int'(tripped), tbl[n].exp_trip);
      chk($sformatf("tbl%0d_peak", n), int'(rd_peak), tbl[n].exp_pk);
    end

    // trip_clear colliding with an update
    do_reset();
    trip_thresh = 17'd12400;
    persist = 4'd1;
    pair(1, 100, -50);
    idle(2);
    trip_clear = 4'b0010;
    tick();
    trip_clear = '0;
    chk("tc_tripped", int'(tripped), 0);
    persist = 4'd2;
    pair(1, 100, -50);
    idle(3);
    chk("tc_cnt_zero", int'(tripped), 0);
    pair(1, 100, -50);
    idle(3);
    chk("tc_cnt_two", int'(tripped), 4'b0010);

    // peak_clear colliding with a peak update
    rd_chan = 2'd0;
    pair(0, 100, -50);
    idle(2);
    peak_clear = 4'b0001;
    tick();
    peak_clear = '0;
    tick();
    chk("pc_peak", int'(rd_peak), 0);
    pair(0, 10, 10);
    idle(4);
    chk("pc_peak_after", int'(rd_peak), 200);

    // broken pairs
    do_reset();
    trip_thresh = '0;
    persist = 4'd1;
    drive(1'b1, 1'b1, 0, 100);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    tick();
    drive(1'b1, 1'b0, 0, 100);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    idle(4);
    chk("bp_gap", int'(tripped), 0);
    drive(1'b1, 1'b1, 1, 100);
    tick();
    drive(1'b1, 1'b1, 2, 100);
    tick();
    drive(1'b1, 1'b0, 0, 100);
    tick();
    drive(1'b0, 1'b0, 0, 0);
    idle(3);
    chk("bp_regate", int'(tripped), 4'b0100);
    rd_chan = 2'd1;
    tick();
    chk("bp_peak1", int'(rd_peak), 0);
    rd_chan = 2'd2;
    tick();
    chk("bp_peak2", int'(rd_peak), 20000);

    // out-of-range channel on the 3-channel instance
    do_reset();
    trip_thresh = '0;
    persist = 4'd1;
    pair(3, 100, 100);
    idle(4);
    chk("oor_tripped", int'(tripped_b), 0);
    chk("oor_any", int'(trip_any_b), 0);
    chk("oor_ref_tripped", int'(tripped), 4'b1000);
    for (int c = 0; c < 4; c++) begin
      rd_chan = 2'(c);
      tick();
      chk($sformatf("oor_peak%0d", c), int'(rd_peak_b), 0);
    end

    // back-to-back pairs on one channel
    do_reset();
    trip_thresh = 17'h1FFFF;
    rd_chan = 2'd3;
    pair(3, 40, 20);
    pair(3, 55, 1);
    pair(3, 50, 0);
    idle(4);
    chk("b2b_peak", int'(rd_peak), 3026);
    chk("b2b_tripped", int'(tripped), 0);

    // reset mid-stream
    do_reset();
    trip_thresh = '0;
    persist = 4'd1;
    rd_chan = 2'd1;
    pair(1, 100, 100);
    idle(4);
    chk("rs_pre_tripped", int'(tripped), 4'b0010);
    pair(0, 100, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_pipe_tripped", int'(tripped), 0);
    chk("rs_pipe_any", int'(trip_any), 0);
    chk("rs_pipe_peak", int'(rd_peak), 0);
    idle(5);
    chk("rs_pipe_after", int'(tripped), 0);
    drive(1'b1, 1'b1, 2, 100);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 2, 100);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    chk("rs_iq_tripped", int'(tripped), 0);
    idle(5);
    chk("rs_iq_after", int'(tripped), 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 9) < 8);
      in_gate = ($urandom_range(0, 9) < 4);
      in_chan = 2'($urandom);
      in_val = 9'($urandom);
      if ($urandom_range(0, 49) == 0) persist = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) trip_thresh = 17'($urandom_range(0, 70000));
      for (int c = 0; c < 4; c++) begin
        trip_clear[c] = ($urandom_range(0, 39) == 0);
        peak_clear[c] = ($urandom_range(0, 39) == 0);
      end
      rd_chan = 2'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
